// File: rtl/terrain_pkg.sv
// terrain_pkg: shared constants, render state encoding and pixel helpers
// for the terrain renderer.
package terrain_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 9;

    localparam logic [2:0] COL_SKY     = 3'b000;
    localparam logic [2:0] COL_GROUND  = 3'b010;
    localparam logic [2:0] COL_SURFACE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        DRAW,
        FIN
    } render_state_t;

    // Heights above the window clamp to a full-height column.
    function automatic logic [6:0] clamp_height(input logic [DATA_W-1:0] q);
        if (q >= DATA_W'(SCREEN_H))
            return 7'(SCREEN_H);
        return q[6:0];
    endfunction

    // First ground row of a column with clamped height hc.
    function automatic logic [7:0] ground_top(input logic [6:0] hc);
        return 8'(SCREEN_H) - {1'b0, hc};
    endfunction

    function automatic logic on_ground(input logic [6:0] row, input logic [6:0] hc);
        return {1'b0, row} >= ground_top(hc);
    endfunction

    function automatic logic on_surface(input logic [6:0] row, input logic [6:0] hc);
        return (hc != 7'd0) && ({1'b0, row} == ground_top(hc));
    endfunction

endpackage

// File: rtl/terrain_render.sv
// terrain_render: sweeps the 160x120 window column by column on each frame
// tick, reading one height per column from the terrain RAM and plotting sky
// or ground for every pixel through the VGA adapter write port.
// Optional build macro: TERRAIN_SURFACE_HIGHLIGHT_EN (top ground pixel of
// each non-empty column drawn in SURFACE_COLOUR).
module terrain_render
    import terrain_pkg::*;
#(
    parameter logic [ADDR_W-1:0] X_BASE         = 10'd0,
    parameter logic [2:0]        SKY_COLOUR     = COL_SKY,
    parameter logic [2:0]        GROUND_COLOUR  = COL_GROUND,
    parameter logic [2:0]        SURFACE_COLOUR = COL_SURFACE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot
);

`ifdef TERRAIN_SURFACE_HIGHLIGHT_EN
    localparam bit HIGHLIGHT = 1'b1;
`else
    localparam bit HIGHLIGHT = 1'b0;
`endif

    render_state_t     r_state, w_state_next;
    logic [7:0]        r_col, w_col_next;
    logic [6:0]        r_row, w_row_next;
    logic [6:0]        r_hc, w_hc_next;
    logic [2:0]        w_colour;
    logic [ADDR_W-1:0] w_addr_next;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next state, counters, height latch and the pixel that the next state will show.
    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_hc_next    = r_hc;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = READ;
                    w_col_next   = '0;
                end
            end
            READ: w_state_next = WAIT;
            WAIT: begin
                w_hc_next    = clamp_height(ram_q);
                w_row_next   = '0;
                w_state_next = DRAW;
            end
            DRAW: begin
                if (r_row < 7'(SCREEN_H - 1)) begin
                    w_row_next = r_row + 7'd1;
                end else if (r_col < 8'(SCREEN_W - 1)) begin
                    w_col_next   = r_col + 8'd1;
                    w_state_next = READ;
                end else begin
                    w_state_next = FIN;
                end
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        w_colour = SKY_COLOUR;
        if (HIGHLIGHT && on_surface(w_row_next, w_hc_next))
            w_colour = SURFACE_COLOUR;
        else if (on_ground(w_row_next, w_hc_next))
            w_colour = GROUND_COLOUR;

        // Address only moves on entry to READ, so it is stable through WAIT and DRAW.
        w_addr_next = ram_addr;
        if (w_state_next == READ)
            w_addr_next = X_BASE + ADDR_W'(w_col_next);
    end

    // Counters and registered outputs; outputs track the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_hc     <= '0;
            ram_addr <= X_BASE;
            x        <= '0;
            y        <= '0;
            colour   <= SKY_COLOUR;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_col    <= w_col_next;
            r_row    <= w_row_next;
            r_hc     <= w_hc_next;
            ram_addr <= w_addr_next;
            x        <= w_col_next;
            y        <= w_row_next;
            colour   <= w_colour;
            plot     <= (w_state_next == DRAW);
            busy     <= (w_state_next inside {READ, WAIT, DRAW});
            done     <= (w_state_next == FIN);
        end
    end

endmodule

// File: tb/tb_terrain_render.sv
// tb_terrain_render: directed bench for terrain_render with a height RAM model.
// A second instance with X_BASE=1020 exercises address wrap.
module tb_terrain_render;

    localparam logic [2:0] SKY = 3'b000;
    localparam logic [2:0] GND = 3'b010;
`ifdef TERRAIN_SURFACE_HIGHLIGHT_EN
    localparam logic [2:0] TOP_EXP = 3'b111;
`else
    localparam logic [2:0] TOP_EXP = 3'b010;
`endif

    logic       clk, reset, start;
    logic       busy, done, plot;
    logic [9:0] ram_addr;
    logic [8:0] ram_q;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    logic       wbusy, wdone, wplot;
    logic [9:0] waddr;
    logic [8:0] wq;
    logic [7:0] wx;
    logic [6:0] wy;
    logic [2:0] wcolour;

    logic [8:0] mem [0:1023];

    int total = 0, bad = 0;
    int cyc = 0, s_start = 0;
    int n_plot = 0, n_order = 0, n_col = 0, n_wcol = 0, n_done = 0, n_wdone = 0;
    int done_n = 0, last_plot_n = 0;
    int unsigned ex = 0, ey = 0;
    logic [2:0] pix  [0:159][0:119];
    logic [2:0] wpix [0:159][0:119];
    logic [9:0] addr_main [0:159];
    logic [9:0] addr_wrap [0:159];

    terrain_render dut (
        .clock(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_q(ram_q), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    terrain_render #(.X_BASE(10'd1020)) dut_wrap (
        .clock(clk), .reset(reset), .start(start), .busy(wbusy), .done(wdone),
        .ram_addr(waddr), .ram_q(wq), .x(wx), .y(wy), .colour(wcolour), .plot(wplot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        wq    <= mem[waddr];
        cyc   <= cyc + 1;
    end

    function automatic logic [2:0] model_col(input logic [9:0] base, input int unsigned cx,
                                             input int unsigned cy);
        logic [9:0]  a;
        int unsigned hc, top;
        a   = base + 10'(cx);
        hc  = (mem[a] >= 9'd120) ? 120 : 32'(mem[a]);
        top = 120 - hc;
`ifdef TERRAIN_SURFACE_HIGHLIGHT_EN
        if (hc != 0 && cy == top) return 3'b111;
`endif
        return (cy >= top) ? 3'b010 : 3'b000;
    endfunction

    // Pixel stream monitor: order, colour model, capture, done timing.
    always @(negedge clk) begin
        if (!reset) begin
            ex = 0;
            ey = 0;
        end else begin
            if (plot) begin
                n_plot++;
                last_plot_n = cyc - s_start + 1;
                if (32'(x) != ex || 32'(y) != ey) n_order++;
                if (x < 8'd160 && y < 7'd120) begin
                    pix[x][y] = colour;
                    if (y == 7'd0) addr_main[x] = ram_addr;
                    if (colour !== model_col(10'd0, 32'(x), 32'(y))) n_col++;
                end
                if (ey == 119) begin
                    ey = 0;
                    ex = (ex == 159) ? 0 : ex + 1;
                end else begin
                    ey++;
                end
            end
            if (wplot && wx < 8'd160 && wy < 7'd120) begin
                wpix[wx][wy] = wcolour;
                if (wy == 7'd0) addr_wrap[wx] = waddr;
                if (wcolour !== model_col(10'd1020, 32'(wx), 32'(wy))) n_wcol++;
            end
            if (done) begin
                n_done++;
                done_n = cyc - s_start + 1;
            end
            if (wdone) n_wdone++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 after the accepted start.
    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        s_start = cyc;
    endtask

    task automatic wait_done(input string tag);
        int unsigned k;
        k = 0;
        while (done !== 1'b1 && k < 25000) begin
            step();
            k++;
        end
        check(tag, done, 1);
    endtask

    int p0, o0, c0, w0, d0;
    logic found;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset hold and idle.
        repeat (3) step();
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_xy", {x, y}, 0);
        check("rst_colour", colour, SKY);
        check("rst_waddr", waddr, 1020);
        reset = 1'b1;
        repeat (100) step();
        check("idle_plots", n_plot, 0);
        check("idle_busy", busy, 0);
        check("idle_done", n_done, 0);
        check("idle_addr", ram_addr, 0);

        // Frame 1: flat terrain, all sky.
        p0 = n_plot; o0 = n_order; c0 = n_col; d0 = n_done;
        pulse_start();
        check("f1_busy_c1", busy, 1);
        check("f1_plot_c1", plot, 0);
        wait_done("f1_done");
        check("f1_done_cycle", done_n, 19521);
        check("f1_last_plot", last_plot_n, 19520);
        check("f1_busy_fin", busy, 0);
        check("f1_plots", n_plot - p0, 19200);
        check("f1_order", n_order - o0, 0);
        check("f1_colour_err", n_col - c0, 0);
        check("f1_pix_159_119", pix[159][119], SKY);
        step();
        check("f1_done_pulse", done, 0);
        check("f1_busy_after", busy, 0);
        check("f1_ndone", n_done - d0, 1);
        check("addr_c0", addr_main[0], 0);
        check("addr_c159", addr_main[159], 159);
        check("waddr_c0", addr_wrap[0], 1020);
        check("waddr_c3", addr_wrap[3], 1023);
        check("waddr_c4", addr_wrap[4], 0);
        check("waddr_c5", addr_wrap[5], 1);
        check("waddr_c159", addr_wrap[159], 155);

        // Frame 2: height c mod 121, column 5 saturated; stray starts mid-sweep and at FIN.
        for (int i = 0; i < 1024; i++) mem[i] = 9'(i % 121);
        mem[5] = 9'd511;
        p0 = n_plot; o0 = n_order; c0 = n_col; w0 = n_wcol; d0 = n_done;
        pulse_start();
        repeat (48) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("f2_done");
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (150) step();
        check("f2_plots", n_plot - p0, 19200);
        check("f2_ndone", n_done - d0, 1);
        check("f2_busy_after", busy, 0);
        check("f2_order", n_order - o0, 0);
        check("f2_colour_err", n_col - c0, 0);
        check("f2_wcolour_err", n_wcol - w0, 0);
        check("c0_r119", pix[0][119], SKY);
        check("c5_r0", pix[5][0], TOP_EXP);
        check("c5_r1", pix[5][1], GND);
        check("c5_r119", pix[5][119], GND);
        check("c30_r89", pix[30][89], SKY);
        check("c30_r90", pix[30][90], TOP_EXP);
        check("c30_r91", pix[30][91], GND);
        check("c30_r119", pix[30][119], GND);
        check("c119_r0", pix[119][0], SKY);
        check("c119_r1", pix[119][1], TOP_EXP);
        check("c120_r0", pix[120][0], TOP_EXP);
        check("c120_r1", pix[120][1], GND);
        // column 130 reads 130 mod 121 = 9
        check("c130_r110", pix[130][110], SKY);
        check("c130_r111", pix[130][111], TOP_EXP);
        check("c159_r81", pix[159][81], SKY);
        check("c159_r82", pix[159][82], TOP_EXP);
        check("w0_r67", wpix[0][67], SKY);
        check("w0_r68", wpix[0][68], TOP_EXP);
        check("w4_r119", wpix[4][119], SKY);
        check("w5_r118", wpix[5][118], SKY);
        check("w5_r119", wpix[5][119], TOP_EXP);
        check("wrap_ndone", n_wdone, 2);

        // Frame 3: asynchronous reset during column 80.
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 15000 && !found; k++) begin
            if (plot === 1'b1 && x == 8'd80) found = 1'b1;
            else step();
        end
        check("f3_reach_c80", found, 1);
        d0 = n_done;
        reset = 1'b0;
        #1;
        check("f3_rst_plot", plot, 0);
        check("f3_rst_busy", busy, 0);
        check("f3_rst_x", x, 0);
        repeat (3) step();
        reset = 1'b1;
        repeat (20) step();
        check("f3_no_done", n_done - d0, 0);
        check("f3_idle_plot", plot, 0);
        pulse_start();
        check("f3_busy_c1", busy, 1);
        step();
        check("f3_plot_c2", plot, 0);
        step();
        check("f3_plot_c3", plot, 1);
        check("f3_x_c3", x, 0);
        check("f3_y_c3", y, 0);
        check("f3_colour_c3", colour, SKY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
